// File: rtl/reg_wb_arbiter_if.sv
// rtl/reg_wb_arbiter_if.sv - requester handshake and register-file write port bundle
interface reg_wb_arbiter_if #(
  parameter int word_width     = 32,
  parameter int reg_addr_width = 5,
  parameter int num_req        = 3
);
  localparam int src_width = (num_req > 1) ? $clog2(num_req) : 1;

  logic                              wb_stall;
  logic [num_req-1:0]                req_valid;
  logic [num_req*reg_addr_width-1:0] req_addr;
  logic [num_req*word_width-1:0]     req_data;
  logic [num_req-1:0]                req_ready;

  logic                              reg_wren;
  logic [reg_addr_width-1:0]         reg_addr;
  logic [word_width-1:0]             reg_data_in;
  logic [src_width-1:0]              wb_src;

  // master: result producers plus register file; slave: the arbiter
  modport master (
    output wb_stall, req_valid, req_addr, req_data,
    input  req_ready, reg_wren, reg_addr, reg_data_in, wb_src
  );

  modport slave (
    input  wb_stall, req_valid, req_addr, req_data,
    output req_ready, reg_wren, reg_addr, reg_data_in, wb_src
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - fixed-priority writeback arbiter with aging and registered write port
module reg_wb_arbiter #(
  parameter int word_width     = 32,
  parameter int reg_addr_width = 5,
  parameter int num_req        = 3,
  parameter int max_wait       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  reg_wb_arbiter_if.slave  wb
);
  localparam int cnt_width = $clog2(max_wait + 1);
  localparam int src_width = (num_req > 1) ? $clog2(num_req) : 1;
  localparam logic [cnt_width-1:0] cnt_max = cnt_width'(max_wait);

  logic [cnt_width-1:0]      wait_cnt_q [num_req];
  logic [cnt_width-1:0]      wait_cnt_d [num_req];

  logic [num_req-1:0]        aged;
  logic [num_req-1:0]        cand;
  logic [num_req-1:0]        grant;
  logic                      grant_any;
  logic [src_width-1:0]      grant_idx;
  logic [reg_addr_width-1:0] sel_addr;
  logic [word_width-1:0]     sel_data;

  logic                      reg_wren_q, reg_wren_d;
  logic [reg_addr_width-1:0] reg_addr_q, reg_addr_d;
  logic [word_width-1:0]     reg_data_q, reg_data_d;
  logic [src_width-1:0]      wb_src_q, wb_src_d;

  always_comb begin : age_detect
    for (int i = 0; i < num_req; i++) begin
      aged[i] = wb.req_valid[i] && (wait_cnt_q[i] == cnt_max);
    end
  end

  // Promoted requesters pre-empt plain priority; within either set the lowest index wins.
  always_comb begin : grant_select
    cand      = (|aged) ? aged : wb.req_valid;
    grant_idx = '0;
    for (int i = num_req - 1; i >= 0; i--) begin
      if (cand[i]) begin
        grant_idx = src_width'(i);
      end
    end
    grant_any = rst_n && !wb.wb_stall && (|cand);
    grant     = grant_any ? (num_req'(1) << grant_idx) : '0;
  end

  always_comb begin : winner_mux
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < num_req; i++) begin
      if (grant_idx == src_width'(i)) begin
        sel_addr = wb.req_addr[i*reg_addr_width +: reg_addr_width];
        sel_data = wb.req_data[i*word_width +: word_width];
      end
    end
  end

  // Stall cycles count as losses, so a stalled requester leaves the stall already promoted.
  always_comb begin : wait_next
    for (int i = 0; i < num_req; i++) begin
      if (wb.req_valid[i] && !grant[i]) begin
        wait_cnt_d[i] = (wait_cnt_q[i] == cnt_max) ? cnt_max
                                                   : wait_cnt_q[i] + cnt_width'(1);
      end else begin
        wait_cnt_d[i] = '0;
      end
    end
  end

  always_comb begin : out_next
    reg_wren_d = 1'b0;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    wb_src_d   = wb_src_q;
    if (grant_any) begin
      reg_wren_d = (sel_addr != '0);
      reg_addr_d = sel_addr;
      reg_data_d = sel_data;
      wb_src_d   = grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < num_req; i++) begin
        wait_cnt_q[i] <= '0;
      end
      reg_wren_q <= 1'b0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
      wb_src_q   <= '0;
    end else begin
      for (int i = 0; i < num_req; i++) begin
        wait_cnt_q[i] <= wait_cnt_d[i];
      end
      reg_wren_q <= reg_wren_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
      wb_src_q   <= wb_src_d;
    end
  end

  assign wb.req_ready   = grant;
  assign wb.reg_wren    = reg_wren_q;
  assign wb.reg_addr    = reg_addr_q;
  assign wb.reg_data_in = reg_data_q;
  assign wb.wb_src      = wb_src_q;
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - self-checking bench for reg_wb_arbiter
module tb_reg_wb_arbiter;
  localparam int ww = 32;
  localparam int aw = 5;
  localparam int nr = 3;
  localparam int mw = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_wb_arbiter_if #(.word_width(ww), .reg_addr_width(aw), .num_req(nr)) wb_if ();

  reg_wb_arbiter #(.word_width(ww), .reg_addr_width(aw), .num_req(nr), .max_wait(mw)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb_if)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: losses counted without bound; promotion means at least max_wait losses.
  int            lost [nr];
  logic          exp_wren;
  logic [aw-1:0] exp_addr;
  logic [ww-1:0] exp_data;
  int            exp_src;
  logic [nr-1:0] last_grant;
  int            m_g;
  logic [nr-1:0] exp_ready;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_ready", wb_if.req_ready, 0);
      check("rst_wren",  wb_if.reg_wren, 0);
      check("rst_addr",  wb_if.reg_addr, 0);
      check("rst_data",  wb_if.reg_data_in, 0);
      check("rst_src",   wb_if.wb_src, 0);
      for (int i = 0; i < nr; i++) lost[i] <= 0;
      exp_wren   <= 1'b0;
      exp_addr   <= '0;
      exp_data   <= '0;
      exp_src    <= 0;
      last_grant <= '0;
    end else begin
      m_g = -1;
      if (!wb_if.wb_stall) begin
        for (int i = 0; i < nr; i++)
          if (m_g < 0 && wb_if.req_valid[i] && lost[i] >= mw) m_g = i;
        for (int i = 0; i < nr; i++)
          if (m_g < 0 && wb_if.req_valid[i]) m_g = i;
      end
      exp_ready = '0;
      if (m_g >= 0) exp_ready[m_g] = 1'b1;
      check("ready", wb_if.req_ready, exp_ready);
      check("wren",  wb_if.reg_wren, exp_wren);
      check("addr",  wb_if.reg_addr, exp_addr);
      check("data",  wb_if.reg_data_in, exp_data);
      check("src",   wb_if.wb_src, exp_src);
      for (int i = 0; i < nr; i++)
        lost[i] <= (wb_if.req_valid[i] && i != m_g) ? lost[i] + 1 : 0;
      if (m_g >= 0) begin
        exp_addr <= wb_if.req_addr[m_g*aw +: aw];
        exp_data <= wb_if.req_data[m_g*ww +: ww];
        exp_src  <= m_g;
        exp_wren <= (wb_if.req_addr[m_g*aw +: aw] != 0);
      end else begin
        exp_wren <= 1'b0;
      end
      last_grant <= exp_ready;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [aw-1:0] a, input logic [ww-1:0] d);
    wb_if.req_valid[i]         = v;
    wb_if.req_addr[i*aw +: aw] = a;
    wb_if.req_data[i*ww +: ww] = d;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < nr; i++) set_req(i, 1'b0, '0, '0);
  endtask

  logic          pend  [nr];
  logic [aw-1:0] paddr [nr];
  logic [ww-1:0] pdata [nr];

  initial begin
    wb_if.wb_stall = 1'b0;
    clear_reqs();
    rst_n = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;

    // single requester
    cyc();
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    #1 check("single_ready", wb_if.req_ready, 3'b001);
    cyc();
    clear_reqs();
    #1;
    check("single_wren", wb_if.reg_wren, 1);
    check("single_addr", wb_if.reg_addr, 5);
    check("single_data", wb_if.reg_data_in, 32'hDEADBEEF);
    check("single_src",  wb_if.wb_src, 0);
    cyc();
    #1 check("single_wren_off", wb_if.reg_wren, 0);

    // fixed priority
    cyc();
    set_req(0, 1'b1, 5'd1, 32'h11);
    set_req(1, 1'b1, 5'd2, 32'h22);
    set_req(2, 1'b1, 5'd3, 32'h33);
    #1 check("prio_first", wb_if.req_ready, 3'b001);
    cyc();
    set_req(0, 1'b0, 5'd1, 32'h11);
    #1 check("prio_second", wb_if.req_ready, 3'b010);
    cyc();
    set_req(1, 1'b0, 5'd2, 32'h22);
    #1 check("prio_third", wb_if.req_ready, 3'b100);
    cyc();
    clear_reqs();
    cyc();

    // aging
    set_req(2, 1'b1, 5'd7, 32'h77);
    for (int k = 1; k <= 5; k++) begin
      if (k < 5) set_req(0, 1'b1, aw'(10 + k), ww'(k));
      #1 check("aging_ready", wb_if.req_ready, (k < 5) ? 3'b001 : 3'b100);
      cyc();
    end
    set_req(2, 1'b0, 5'd7, 32'h77);
    #1;
    check("aging_wren", wb_if.reg_wren, 1);
    check("aging_addr", wb_if.reg_addr, 7);
    check("aging_src",  wb_if.wb_src, 2);
    check("aging_held_ready", wb_if.req_ready, 3'b001);
    cyc();
    clear_reqs();
    cyc();

    // x0 write
    set_req(1, 1'b1, 5'd0, 32'h1234);
    #1 check("x0_ready", wb_if.req_ready, 3'b010);
    cyc();
    clear_reqs();
    #1;
    check("x0_wren", wb_if.reg_wren, 0);
    check("x0_src",  wb_if.wb_src, 1);
    check("x0_data", wb_if.reg_data_in, 32'h1234);
    cyc();

    // stall
    wb_if.wb_stall = 1'b1;
    set_req(1, 1'b1, 5'd9, 32'h99);
    for (int k = 0; k < 6; k++) begin
      #1 check("stall_ready", wb_if.req_ready, 0);
      cyc();
    end
    wb_if.wb_stall = 1'b0;
    set_req(0, 1'b1, 5'd4, 32'h44);
    #1 check("stall_release", wb_if.req_ready, 3'b010);
    cyc();
    set_req(1, 1'b0, 5'd9, 32'h99);
    #1 check("stall_after", wb_if.req_ready, 3'b001);
    cyc();
    clear_reqs();
    cyc();

    // reset mid-operation
    set_req(0, 1'b1, 5'd6, 32'h66);
    cyc();
    clear_reqs();
    #1 check("pre_rst_wren", wb_if.reg_wren, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_wren", wb_if.reg_wren, 0);
    check("async_rst_addr", wb_if.reg_addr, 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    #1;
    check("post_rst_wren", wb_if.reg_wren, 0);
    check("post_rst_data", wb_if.reg_data_in, 0);
    check("post_rst_src",  wb_if.wb_src, 0);
    cyc();

    // randomized traffic against the model
    for (int i = 0; i < nr; i++) begin
      pend[i]  = 1'b0;
      paddr[i] = '0;
      pdata[i] = '0;
    end
    for (int c = 0; c < 3000; c++) begin
      cyc();
      rst_n = ($urandom_range(0, 399) != 0);
      wb_if.wb_stall = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < nr; i++) begin
        if (pend[i] && last_grant[i]) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]  = 1'b1;
          paddr[i] = ($urandom_range(0, 7) == 0) ? '0 : aw'($urandom);
          pdata[i] = ww'($urandom);
        end
        set_req(i, pend[i], paddr[i], pdata[i]);
      end
    end
    cyc();
    rst_n = 1'b1;
    wb_if.wb_stall = 1'b0;
    clear_reqs();
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Shares the single register-file write port between several result producers: the single-cycle ALU path, the load unit and the multi-cycle mul/div unit. Each cycle it picks at most one producer by fixed priority with aging, and acknowledges it with a valid/ready handshake. It then drives the register-file write port from a one-cycle registered stage. It sits between the execute/memory result sources and the register file, replacing direct writeback wiring when more than one unit can retire in the same cycle.

## Interface
- word_width, 32, data width of a register
- reg_addr_width, 5, register index width
- num_req, 3, number of requesters; index 0 = ALU, 1 = load unit, 2 = mul/div
- max_wait, 4, losing cycles after which a waiting requester is promoted

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- wb_stall  in  1  blocks all grants this cycle
- req_valid  in  num_req  requester i has a result pending
- req_addr  in  num_req*reg_addr_width  destination register; slice i is requester i
- req_data  in  num_req*word_width  result data; slice i is requester i
- req_ready  out  num_req  one-hot or zero; grant to requester i this cycle
- reg_wren  out  1  register-file write enable (registered)
- reg_addr  out  reg_addr_width  register-file write index (registered)
- reg_data_in  out  word_width  register-file write data (registered)
- wb_src  out  $clog2(num_req)  index of the requester whose write is on the port (registered)

## Operation
**Handshake**
- A transfer occurs when req_valid[i] & req_ready[i] are both high.
- A requester holds valid, addr and data stable until it is accepted.
- req_valid must not depend combinationally on req_ready.

**Grant selection** (combinational; at most one req_ready bit high)
- If wb_stall = 1, req_ready = 0.
- Otherwise, if any valid requester has wait_cnt[i] == max_wait, the lowest such index wins.
- Otherwise, the lowest valid index wins.
- If no requester is valid, req_ready = 0.

**Wait counters**
- One counter per requester, width $clog2(max_wait+1).
- valid & ~ready: the counter increments, saturating at max_wait. This includes cycles lost to wb_stall.
- Accepted, or valid low: the counter clears to 0.

**Output stage** (registered)
- On accept of requester g, the next cycle drives:
  - reg_addr = req_addr[g]
  - reg_data_in = req_data[g]
  - wb_src = g
  - reg_wren = (req_addr[g] != 0)
- A write to x0 is accepted and consumed but produces no write enable.
- Cycle with no accept: reg_wren = 0; reg_addr, reg_data_in and wb_src hold their previous values.

**Reset**
- Asynchronously clears all wait counters, reg_wren, reg_addr, reg_data_in and wb_src to 0.
- req_ready is 0 while rst_n = 0.
- Reset mid-operation drops any pending output-stage write.
- Requesters still holding valid after reset releases are arbitrated from zeroed counters.

## Timing
- Grant latency: req_ready rises in the same cycle as req_valid if the requester wins.
- Write latency: accept in cycle N puts the write on the port in cycle N+1. The register file samples it at the end of N+1.
- Throughput: one write per cycle; back-to-back accepts from the same or different requesters are allowed.
- Starvation bound, absent wb_stall: a continuously valid requester is granted no later than max_wait + num_req - 1 cycles after its first losing cycle.
- wb_stall is combinational to req_ready and has no effect on the output register already loaded.
- Simultaneous saturation: the lowest index among the saturated requesters wins; the others remain saturated and win in index order on the following cycles.

## Test plan
- **Single requester.** Reset, then ALU valid with addr=5, data=0xDEADBEEF for 1 cycle -> req_ready=3'b001 that cycle. Next cycle: reg_wren=1, reg_addr=5, reg_data_in=0xDEADBEEF, wb_src=0. The cycle after: reg_wren=0.
- **Fixed priority.** All three valid in the same cycle (addrs 1, 2, 3) -> requester 0 is granted first.
- **Aging.** Requester 0 valid every cycle with a new addr; requester 2 valid (addr=7) -> req_ready[2] is granted on the 5th cycle (max_wait=4). The write of addr 7 appears the following cycle. wait_cnt[2] returns to 0.
- **x0 write.** Load unit valid with addr=0, data=0x1234 -> accepted (req_ready[1]=1). Next cycle reg_wren=0 and wb_src=1.
- **Stall.** wb_stall=1 for 6 cycles with requester 1 valid -> req_ready=0 throughout and its counter saturates at 4. On stall release, requester 1 wins over a newly valid requester 0.
- **Reset mid-operation.** Assert rst_n=0 in the cycle after an accept -> reg_wren drops to 0 immediately, with no clock edge required. After release, all outputs are 0 until the next accept.
